// File: rtl/flag_pacer_pkg.sv
// Shared definitions for the flag pacer: FSM state encoding and counter limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flag_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GAP      = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  // All-ones value of a w-bit counter (w kept well below 32).
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Up/down counter that saturates at all-ones and never wraps below zero.
// Latency: count updates on the clock edge after inc/dec; drop_o is combinational.
// Backpressure: none; an increment at max without a decrement is dropped and reported.
module sat_updown_counter
  import flag_pacer_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         drop_o
);

  localparam logic [W-1:0] MAX = W'(cnt_max(W));
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc and dec cancel, so a full counter still accepts then.
  always_comb begin
    cnt_d  = cnt_q;
    drop_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == MAX) begin
        drop_o = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/flag_pacer.sv
// Queues bursty event strobes and re-emits them as flag pulses spaced for a pulse synchronizer.
// Latency: event in cycle N from IDLE with nothing pending gives flag_out in cycle N+1.
// Backpressure: none; events beyond the pending counter's capacity are dropped and flagged in overflow.
module flag_pacer
  import flag_pacer_pkg::*;
#(
  parameter int unsigned GAP     = 6,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned USE_ACK = 0,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_in,
  input  logic             ack_in,
  input  logic             err_clr,
  output logic             flag_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  state_e           state_q, state_d;
  logic             flag_q, flag_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic             emit;
  logic             to_hit;
  logic             drop;

  sat_updown_counter #(
    .W(CNT_W)
  ) u_pending (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (event_in),
    .dec_i  (emit),
    .cnt_o  (pending),
    .drop_o (drop)
  );

  // Pacing FSM: emit from IDLE, then hold off for the gap (and optionally the ack) before the next pulse.
  always_comb begin
    state_d = state_q;
    flag_d  = 1'b0;
    gap_d   = gap_q;
    to_d    = to_q;
    emit    = 1'b0;
    to_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((pending != '0) || event_in) begin
          emit   = 1'b1;
          flag_d = 1'b1;
          if (USE_ACK != 0) begin
            state_d = ST_WAIT_ACK;
            to_d    = '0;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      ST_WAIT_ACK: begin
        // An ack arriving on the timeout cycle takes priority, so no error is raised.
        if (ack_in) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else if (to_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error flags: a new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d = drop   ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    tmo_d = to_hit ? 1'b1 : (err_clr ? 1'b0 : tmo_q);
  end

  // State and counter registers; reset aborts any queued work immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      flag_q  <= 1'b0;
      gap_q   <= '0;
      to_q    <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign flag_out    = flag_q;
  assign busy        = (state_q != ST_IDLE) || (pending != '0);
  assign overflow    = ovf_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_flag_pacer.sv
// Scoreboard bench for flag_pacer: three instances (default, CNT_W=2, USE_ACK=1).
// Expectations are queued up front; a negedge monitor pops and compares them.
// Flag pulses are matched against per-instance queues of expected pulse cycles.
module tb_flag_pacer;

  localparam int END_CYC = 200;

  localparam int A_FLAG = 0;
  localparam int A_PEND = 1;
  localparam int A_BUSY = 2;
  localparam int A_OVF  = 3;
  localparam int A_TMO  = 4;
  localparam int B_FLAG = 5;
  localparam int B_PEND = 6;
  localparam int B_BUSY = 7;
  localparam int B_OVF  = 8;
  localparam int C_PEND = 9;
  localparam int C_BUSY = 10;
  localparam int C_TMO  = 11;
  localparam int C_FLAG = 12;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string nm;
  } chk_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  chk_t chk_q[$];
  chk_t keep_q[$];
  int   pq[3][$];
  int   exp_c;
  logic fl;

  logic rst_a, ev_a, ack_a, clr_a, flag_a, busy_a, ovf_a, tmo_a;
  logic rst_b, ev_b, ack_b, clr_b, flag_b, busy_b, ovf_b, tmo_b;
  logic rst_c, ev_c, ack_c, clr_c, flag_c, busy_c, ovf_c, tmo_c;
  logic [3:0] pend_a;
  logic [1:0] pend_b;
  logic [3:0] pend_c;

  flag_pacer u_a (
    .clk(clk), .rst(rst_a), .event_in(ev_a), .ack_in(ack_a), .err_clr(clr_a),
    .flag_out(flag_a), .pending(pend_a), .busy(busy_a), .overflow(ovf_a), .timeout_err(tmo_a)
  );

  flag_pacer #(.GAP(6), .CNT_W(2), .USE_ACK(0), .TIMEOUT(64)) u_b (
    .clk(clk), .rst(rst_b), .event_in(ev_b), .ack_in(ack_b), .err_clr(clr_b),
    .flag_out(flag_b), .pending(pend_b), .busy(busy_b), .overflow(ovf_b), .timeout_err(tmo_b)
  );

  flag_pacer #(.GAP(6), .CNT_W(4), .USE_ACK(1), .TIMEOUT(64)) u_c (
    .clk(clk), .rst(rst_c), .event_in(ev_c), .ack_in(ack_c), .err_clr(clr_c),
    .flag_out(flag_c), .pending(pend_c), .busy(busy_c), .overflow(ovf_c), .timeout_err(tmo_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sig_val(input int s);
    case (s)
      A_FLAG:  return int'(flag_a);
      A_PEND:  return int'(pend_a);
      A_BUSY:  return int'(busy_a);
      A_OVF:   return int'(ovf_a);
      A_TMO:   return int'(tmo_a);
      B_FLAG:  return int'(flag_b);
      B_PEND:  return int'(pend_b);
      B_BUSY:  return int'(busy_b);
      B_OVF:   return int'(ovf_b);
      C_PEND:  return int'(pend_c);
      C_BUSY:  return int'(busy_c);
      C_TMO:   return int'(tmo_c);
      C_FLAG:  return int'(flag_c);
      default: return -1;
    endcase
  endfunction

  task automatic ex(input int c, input int s, input int v, input string nm);
    chk_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    e.nm  = nm;
    chk_q.push_back(e);
  endtask

  // Advance to 1 time unit after the posedge that starts cycle n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare queued expectations for this cycle and match flag pulses.
  always @(negedge clk) begin
    keep_q.delete();
    foreach (chk_q[i]) begin
      if (chk_q[i].cyc == cyc) begin
        total++;
        if (sig_val(chk_q[i].sig) != chk_q[i].val) begin
          bad++;
          $display("FAIL %s @cycle %0d: got %0d, want %0d",
                   chk_q[i].nm, cyc, sig_val(chk_q[i].sig), chk_q[i].val);
        end
      end else begin
        keep_q.push_back(chk_q[i]);
      end
    end
    chk_q = keep_q;

    for (int k = 0; k < 3; k++) begin
      fl = (k == 0) ? flag_a : ((k == 1) ? flag_b : flag_c);
      if (fl) begin
        total++;
        if (pq[k].size() == 0) begin
          bad++;
          $display("FAIL pulse_%0d: flag_out high at cycle %0d, want no pulse", k, cyc);
        end else begin
          exp_c = pq[k].pop_front();
          if (exp_c != cyc) begin
            bad++;
            $display("FAIL pulse_%0d: pulse at cycle %0d, want cycle %0d", k, cyc, exp_c);
          end
        end
      end
    end

    if (cyc == END_CYC) begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (pq[k].size() != 0) begin
          bad++;
          $display("FAIL pulse_%0d_missing: %0d expected pulses not seen, want 0", k, pq[k].size());
        end
      end
      total++;
      if (chk_q.size() != 0) begin
        bad++;
        $display("FAIL checks_left: %0d unchecked, want 0", chk_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst_a = 1'b1; ev_a = 1'b0; ack_a = 1'b0; clr_a = 1'b0;
    rst_b = 1'b1; ev_b = 1'b0; ack_b = 1'b0; clr_b = 1'b0;
    rst_c = 1'b1; ev_c = 1'b0; ack_c = 1'b0; clr_c = 1'b0;

    // Reset state.
    ex(1, A_FLAG, 0, "rst_a_flag");
    ex(1, A_PEND, 0, "rst_a_pend");
    ex(1, A_BUSY, 0, "rst_a_busy");
    ex(1, A_OVF,  0, "rst_a_ovf");
    ex(1, A_TMO,  0, "rst_a_tmo");
    ex(1, C_TMO,  0, "rst_c_tmo");

    // A: single event at 10.
    pq[0].push_back(11);
    ex(10, A_BUSY, 0, "a1_busy_pre");
    for (int c = 11; c <= 16; c++) ex(c, A_BUSY, 1, "a1_busy");
    ex(17, A_BUSY, 0, "a1_busy_end");
    ex(11, A_PEND, 0, "a1_pend");
    // A: three events 30..32.
    pq[0].push_back(31); pq[0].push_back(38); pq[0].push_back(45);
    ex(31, A_PEND, 0, "a2_pend31");
    ex(32, A_PEND, 1, "a2_pend32");
    ex(33, A_PEND, 2, "a2_pend33");
    ex(37, A_PEND, 2, "a2_pend37");
    ex(38, A_PEND, 1, "a2_pend38");
    ex(44, A_PEND, 1, "a2_pend44");
    ex(45, A_PEND, 0, "a2_pend45");
    ex(50, A_BUSY, 1, "a2_busy50");
    ex(51, A_BUSY, 0, "a2_busy51");
    ex(51, A_OVF,  0, "a2_ovf");
    // A: five events 60..64, reset during the pulse at 68 with pending=3.
    pq[0].push_back(61);
    ex(65, A_PEND, 4, "a6_pend65");
    ex(68, A_FLAG, 0, "a6_rst_flag");
    ex(68, A_PEND, 0, "a6_rst_pend");
    ex(68, A_BUSY, 0, "a6_rst_busy");
    ex(68, A_OVF,  0, "a6_rst_ovf");
    ex(72, A_BUSY, 0, "a6_busy72");
    pq[0].push_back(73);
    ex(73, A_PEND, 0, "a6_pend73");
    ex(73, A_BUSY, 1, "a6_busy73");

    // B (CNT_W=2): six events 10..15.
    pq[1].push_back(11); pq[1].push_back(18); pq[1].push_back(25); pq[1].push_back(32);
    ex(11, B_PEND, 0, "b3_pend11");
    ex(12, B_PEND, 1, "b3_pend12");
    ex(13, B_PEND, 2, "b3_pend13");
    ex(14, B_PEND, 3, "b3_pend14");
    ex(16, B_PEND, 3, "b3_pend16");
    ex(18, B_PEND, 2, "b3_pend18");
    ex(25, B_PEND, 1, "b3_pend25");
    ex(32, B_PEND, 0, "b3_pend32");
    ex(14, B_OVF, 0, "b3_ovf14");
    ex(15, B_OVF, 1, "b3_ovf15");
    ex(40, B_OVF, 1, "b3_ovf40");
    ex(41, B_OVF, 0, "b3_ovf_clr");
    // B: drop coincident with err_clr, then reset mid-GAP.
    pq[1].push_back(51);
    ex(54, B_PEND, 3, "b_pend54");
    ex(54, B_OVF,  0, "b_ovf54");
    ex(55, B_OVF,  1, "b_ovf_setwins");
    ex(56, B_PEND, 0, "b_rst_pend");
    ex(56, B_OVF,  0, "b_rst_ovf");
    ex(56, B_BUSY, 0, "b_rst_busy");
    ex(56, B_FLAG, 0, "b_rst_flag");
    // B: event at max while consuming is accepted.
    pq[1].push_back(61); pq[1].push_back(68); pq[1].push_back(75);
    pq[1].push_back(82); pq[1].push_back(89);
    ex(64, B_PEND, 3, "b_pend64");
    ex(66, B_PEND, 3, "b_pend66");
    ex(68, B_PEND, 3, "b_pend68");
    ex(75, B_PEND, 2, "b_pend75");
    ex(82, B_PEND, 1, "b_pend82");
    ex(89, B_PEND, 0, "b_pend89");
    ex(64, B_OVF, 0, "b_ovf64");
    ex(68, B_OVF, 0, "b_ovf68");
    ex(90, B_OVF, 0, "b_ovf90");

    // C (USE_ACK=1): ack after 5 cycles, stray acks in GAP/IDLE.
    pq[2].push_back(11); pq[2].push_back(31); pq[2].push_back(102); pq[2].push_back(181);
    ex(16, C_BUSY, 1, "c4_busy16");
    ex(22, C_BUSY, 1, "c4_busy22");
    ex(23, C_BUSY, 0, "c4_busy23");
    ex(23, C_TMO,  0, "c4_tmo23");
    // C: no ack -> timeout 64 cycles after pulse at 31.
    ex(41, C_PEND, 1, "c4_pend41");
    ex(94, C_TMO,  0, "c4_tmo94");
    ex(95, C_TMO,  1, "c4_tmo95");
    ex(96, C_TMO,  1, "c4_tmo96");
    ex(97, C_TMO,  0, "c4_tmo_clr");
    ex(100, C_BUSY, 1, "c4_busy100");
    ex(101, C_BUSY, 1, "c4_busy101");
    ex(101, C_PEND, 1, "c4_pend101");
    ex(102, C_PEND, 0, "c4_pend102");
    // C: ack on the timeout cycle.
    ex(165, C_FLAG, 0, "c5_flag165");
    ex(166, C_TMO, 0, "c5_tmo166");
    ex(170, C_TMO, 0, "c5_tmo170");
    ex(171, C_BUSY, 1, "c5_busy171");
    ex(172, C_BUSY, 0, "c5_busy172");
    ex(189, C_BUSY, 1, "c5_busy189");
    ex(190, C_BUSY, 0, "c5_busy190");
    ex(190, C_TMO,  0, "c5_tmo190");

    fork
      begin
        goto(2);  rst_a = 1'b0;
        goto(10); ev_a = 1'b1;
        goto(11); ev_a = 1'b0;
        goto(30); ev_a = 1'b1;
        goto(33); ev_a = 1'b0;
        goto(60); ev_a = 1'b1;
        goto(65); ev_a = 1'b0;
        goto(68); rst_a = 1'b1;
        goto(70); rst_a = 1'b0;
        goto(72); ev_a = 1'b1;
        goto(73); ev_a = 1'b0;
      end
      begin
        goto(2);  rst_b = 1'b0;
        goto(10); ev_b = 1'b1;
        goto(16); ev_b = 1'b0;
        goto(40); clr_b = 1'b1;
        goto(41); clr_b = 1'b0;
        goto(50); ev_b = 1'b1;
        goto(54); clr_b = 1'b1;
        goto(55); ev_b = 1'b0; clr_b = 1'b0;
        goto(56); rst_b = 1'b1;
        goto(58); rst_b = 1'b0;
        goto(60); ev_b = 1'b1;
        goto(64); ev_b = 1'b0;
        goto(67); ev_b = 1'b1;
        goto(68); ev_b = 1'b0;
      end
      begin
        goto(2);   rst_c = 1'b0;
        goto(10);  ev_c = 1'b1;
        goto(11);  ev_c = 1'b0;
        goto(16);  ack_c = 1'b1;
        goto(17);  ack_c = 1'b0;
        goto(19);  ack_c = 1'b1;
        goto(20);  ack_c = 1'b0;
        goto(25);  ack_c = 1'b1;
        goto(26);  ack_c = 1'b0;
        goto(30);  ev_c = 1'b1;
        goto(31);  ev_c = 1'b0;
        goto(40);  ev_c = 1'b1;
        goto(41);  ev_c = 1'b0;
        goto(96);  clr_c = 1'b1;
        goto(97);  clr_c = 1'b0;
        goto(165); ack_c = 1'b1;
        goto(166); ack_c = 1'b0;
        goto(175); ack_c = 1'b1;
        goto(176); ack_c = 1'b0;
        goto(180); ev_c = 1'b1;
        goto(181); ev_c = 1'b0;
        goto(183); ack_c = 1'b1;
        goto(184); ack_c = 1'b0;
      end
    join
  end

endmodule
